spi_async_fifo: RTL

Dual-clock FIFO for the SPI subsystem. It carries data words between the system-side write clock and the SPI-side read clock, and it supersedes the single-clock two-entry SPI FIFO. Depth is parametrised (power of two), clock-domain crossing uses Gray-coded pointers, and it adds fill counts and almost-full/almost-empty thresholds. Writers sit on wclk (register/DMA side); the SPI shift engine reads on rclk.

---
 rtl/spi_fifo_pkg.sv | 15 +
 rtl/spi_ptr_sync.sv | 17 +
 rtl/spi_async_fifo.sv | 100 ++++++++++
 3 files changed

// File: rtl/spi_fifo_pkg.sv
// spi_fifo_pkg: shared defaults and Gray-code helpers for the SPI dual-clock FIFO
package spi_fifo_pkg;
  localparam int SPI_FIFO_WIDTH = 16;
  localparam int SPI_FIFO_DEPTH = 8;
  // Helpers work on any pointer width up to 32: callers zero-extend in and truncate out.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/spi_ptr_sync.sv
// spi_ptr_sync: STAGES-deep flop chain carrying a Gray pointer into another clock domain
module spi_ptr_sync #(
  parameter int N = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  logic [STAGES-1:0][N-1:0] chain;
  // shift the pointer through the chain; async active-low clear
  always_ff @(posedge clk or negedge rst)
    if (!rst) chain <= '0;
    else chain <= {chain[STAGES-2:0], d};
  assign q = chain[STAGES-1];
endmodule

// File: rtl/spi_async_fifo.sv
// spi_async_fifo: Gray-pointer dual-clock FIFO with fill counts and thresholds; SPI_FIFO_ERR_FLAG_EN adds sticky overflow/underflow flags
module spi_async_fifo
  import spi_fifo_pkg::*;
#(
  parameter int WIDTH = SPI_FIFO_WIDTH,
  parameter int DEPTH = SPI_FIFO_DEPTH,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             wclk,
  input  logic             rclk,
  input  logic             rst,
  input  logic             winc,
  input  logic [WIDTH-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  output logic [AW:0]      wcount,
  input  logic             rinc,
  output logic [WIDTH-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [AW:0]      rcount
`ifdef SPI_FIFO_ERR_FLAG_EN
  ,
  output logic             woverflow,
  output logic             runderflow
`endif
);
  localparam int PW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wbin, wgray, rgray_sync, wbin_next, wgray_next, wcount_next;
  logic [AW:0] rbin, rgray, wgray_sync, rbin_next, rgray_next, rcount_next;
  logic [1:0] rrst_sync;
  logic rrst, wen, ren;
  assign wen = winc && !wfull;
  assign ren = rinc && !rempty;
  assign rrst = rrst_sync[1];
  // next pointers and pessimistic occupancy in each domain
  always_comb begin
    wbin_next = wbin + PW'(wen);
    wgray_next = PW'(bin2gray(32'(wbin_next)));
    wcount_next = wbin_next - PW'(gray2bin(32'(rgray_sync)));
    rbin_next = rbin + PW'(ren);
    rgray_next = PW'(bin2gray(32'(rbin_next)));
    rcount_next = PW'(gray2bin(32'(wgray_sync))) - rbin_next;
  end
  // write-domain pointers and flags
  always_ff @(posedge wclk or negedge rst)
    if (!rst) begin
      wbin <= '0;
      wgray <= '0;
      wfull <= 1'b0;
      wcount <= '0;
      walmost_full <= 1'b0;
    end else begin
      wbin <= wbin_next;
      wgray <= wgray_next;
      wfull <= wgray_next == {~rgray_sync[AW:AW-1], rgray_sync[AW-2:0]};
      wcount <= wcount_next;
      walmost_full <= wcount_next >= PW'(AFULL_TH);
    end
  // storage write port; contents need no reset since pointers gate visibility
  always_ff @(posedge wclk)
    if (wen) mem[wbin[AW-1:0]] <= wdata;
  // read-domain reset: asserts with rst, releases two rclk edges later
  always_ff @(posedge rclk or negedge rst)
    if (!rst) rrst_sync <= '0;
    else rrst_sync <= {rrst_sync[0], 1'b1};
  // read-domain pointers, flags and registered read data
  always_ff @(posedge rclk or negedge rrst)
    if (!rrst) begin
      rbin <= '0;
      rgray <= '0;
      rempty <= 1'b1;
      rcount <= '0;
      ralmost_empty <= 1'b1;
      rdata <= '0;
    end else begin
      rbin <= rbin_next;
      rgray <= rgray_next;
      rempty <= rgray_next == wgray_sync;
      rcount <= rcount_next;
      ralmost_empty <= rcount_next <= PW'(AEMPTY_TH);
      if (ren) rdata <= mem[rbin[AW-1:0]];
    end
  spi_ptr_sync #(.N(PW), .STAGES(SYNC_STAGES)) u_w2r (.clk(rclk), .rst(rrst), .d(wgray), .q(wgray_sync));
  spi_ptr_sync #(.N(PW), .STAGES(SYNC_STAGES)) u_r2w (.clk(wclk), .rst(rst), .d(rgray), .q(rgray_sync));
`ifdef SPI_FIFO_ERR_FLAG_EN
  // sticky write-while-full flag
  always_ff @(posedge wclk or negedge rst)
    if (!rst) woverflow <= 1'b0;
    else if (winc && wfull) woverflow <= 1'b1;
  // sticky read-while-empty flag
  always_ff @(posedge rclk or negedge rrst)
    if (!rrst) runderflow <= 1'b0;
    else if (rinc && rempty) runderflow <= 1'b1;
`endif
endmodule
